// File: rtl/spc_stack_pkg.sv
// ---------------------------------------------------------------------------
// spc_stack_pkg
// Shared constants and types for the spc_stack LIFO.
//   DEFAULT_WIDTH       default data word width (19 bits)
//   DEFAULT_DEPTH_LOG2  default log2 of the entry count (5 -> 32 entries)
//   op_e                per-cycle operation decoded from PUSH/POP
//   decodeOp()          maps the PUSH/POP request pair onto op_e
// ---------------------------------------------------------------------------
package spc_stack_pkg;

    localparam int DEFAULT_WIDTH      = 19;
    localparam int DEFAULT_DEPTH_LOG2 = 5;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // PUSH and POP together means replace-top, not "push then pop".
    function automatic op_e decodeOp(input logic push, input logic pop);
        op_e op;
        unique case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPL;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/spc_stack_updn_counter.sv
// ---------------------------------------------------------------------------
// updn_counter
// Synchronous up/down counter with enable and terminal-count outputs.
// It saturates at 0 and at MAX, so it can never wrap even if the enable is
// asserted at a terminal count.
//   clk_i    clock, all updates on the rising edge
//   rst_ni   synchronous active-low reset, clears the count to 0
//   en_i     count enable
//   up_i     1 = count up, 0 = count down (only while en_i)
//   cnt_o    current count
//   zero_o   high when cnt_o == 0
//   max_o    high when cnt_o == MAX
// ---------------------------------------------------------------------------
module updn_counter #(
    parameter int              WIDTH = 6,
    parameter logic [WIDTH-1:0] MAX  = WIDTH'(32)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o,
    output logic             max_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: step only when enabled and not already at the terminal
    // value in the direction of travel.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if (up_i && (cnt_q != MAX)) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else if (!up_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign max_o  = (cnt_q == MAX);

endmodule

// File: rtl/spc_stack.sv
// ---------------------------------------------------------------------------
// spc_stack
// LIFO stack of 2**DEPTH_LOG2 words of WIDTH bits with replace-top support
// and optional sticky overflow/underflow flags.
//   CLK      clock, all state changes on the rising edge
//   RESET_N  synchronous active-low reset (clears count and flags only)
//   PUSH     push DIN this cycle
//   POP      pop the top entry this cycle (PUSH+POP = replace top)
//   DIN      word to push / replace with
//   DOUT     current top-of-stack word, zero while empty
//   COUNT    number of valid entries, 0..DEPTH
//   EMPTY    COUNT == 0
//   FULL     COUNT == DEPTH
//   OVF      sticky: push attempted while full
//   UNF      sticky: pop attempted while empty
// Build option: define SPC_STACK_ERR_EN to implement OVF/UNF; otherwise
// both are tied low and illegal requests are simply ignored.
// ---------------------------------------------------------------------------
module spc_stack
    import spc_stack_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic [WIDTH-1:0]      DIN,
    output logic [WIDTH-1:0]      DOUT,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  OVF,
    output logic                  UNF
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];

    op_e                   op;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  cntEn;
    logic                  cntUp;
    logic                  wrEn;
    logic [DEPTH_LOG2-1:0] wrAddr;
    logic [DEPTH_LOG2-1:0] topIdx;
    logic [DEPTH_LOG2-1:0] freeIdx;

    assign op      = decodeOp(PUSH, POP);
    assign freeIdx = count[DEPTH_LOG2-1:0];
    // At COUNT==DEPTH the low bits are zero, so subtracting in the narrow
    // width still lands on DEPTH-1.
    assign topIdx  = count[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);

    updn_counter #(
        .WIDTH (CW),
        .MAX   (CW'(DEPTH))
    ) u_count (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .en_i   (cntEn),
        .up_i   (cntUp),
        .cnt_o  (count),
        .zero_o (empty),
        .max_o  (full)
    );

    // Operation control. A replace on an empty stack degenerates to a plain
    // push; a replace on a full stack is allowed because it does not grow.
    always_comb begin
        cntEn  = 1'b0;
        cntUp  = 1'b0;
        wrEn   = 1'b0;
        wrAddr = freeIdx;
        unique case (op)
            OP_PUSH: begin
                if (!full) begin
                    wrEn  = 1'b1;
                    cntEn = 1'b1;
                    cntUp = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    cntEn = 1'b1;
                end
            end
            OP_REPL: begin
                wrEn = 1'b1;
                if (empty) begin
                    cntEn = 1'b1;
                    cntUp = 1'b1;
                end else begin
                    wrAddr = topIdx;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage array. It has no reset; the write is only gated off during
    // reset so that reset cleanly wins over a same-cycle push.
    always_ff @(posedge CLK) begin
        if (RESET_N && wrEn) begin
            mem_q[wrAddr] <= DIN;
        end
    end

    assign DOUT  = empty ? '0 : mem_q[topIdx];
    assign COUNT = count;
    assign EMPTY = empty;
    assign FULL  = full;

`ifdef SPC_STACK_ERR_EN
    logic ovf_q;
    logic ovf_d;
    logic unf_q;
    logic unf_d;

    // Sticky flags: once set they only clear on reset.
    always_comb begin
        ovf_d = ovf_q | ((op == OP_PUSH) && full);
        unf_d = unf_q | (empty && ((op == OP_POP) || (op == OP_REPL)));
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign OVF = ovf_q;
    assign UNF = unf_q;
`else
    assign OVF = 1'b0;
    assign UNF = 1'b0;
`endif

endmodule

// File: tb/tb_spc_stack.sv
// ---------------------------------------------------------------------------
// tb_spc_stack
// Directed and randomized checks of spc_stack against a queue-based
// reference model. Flag expectations follow SPC_STACK_ERR_EN.
// ---------------------------------------------------------------------------
module tb_spc_stack;

    localparam int WIDTH = 19;
    localparam int DEPTH = 32;
`ifdef SPC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic             CLK;
    logic             RESET_N;
    logic             PUSH;
    logic             POP;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] DOUT;
    logic [5:0]       COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             OVF;
    logic             UNF;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] stk[$];
    bit               mOvf;
    bit               mUnf;

    spc_stack dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .PUSH    (PUSH),
        .POP     (POP),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .COUNT   (COUNT),
        .EMPTY   (EMPTY),
        .FULL    (FULL),
        .OVF     (OVF),
        .UNF     (UNF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: the stack is a queue whose back is the top.
    task automatic modelStep(input bit rstN, input bit push, input bit pop,
                             input logic [WIDTH-1:0] din);
        if (!rstN) begin
            stk.delete();
            mOvf = 0;
            mUnf = 0;
        end else if (push && pop) begin
            if (stk.size() > 0) begin
                stk[stk.size()-1] = din;
            end else begin
                stk.push_back(din);
                mUnf = 1;
            end
        end else if (push) begin
            if (stk.size() < DEPTH) stk.push_back(din);
            else mOvf = 1;
        end else if (pop) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else mUnf = 1;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model on the same edge, settle past it.
    task automatic applyStimulus(input bit rstN, input bit push, input bit pop,
                                 input logic [WIDTH-1:0] din);
        RESET_N = rstN;
        PUSH    = push;
        POP     = pop;
        DIN     = din;
        @(posedge CLK);
        modelStep(rstN, push, pop, din);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] expDout;
        expDout = (stk.size() == 0) ? '0 : stk[stk.size()-1];
        checkVal({tag, ".count"}, 32'(COUNT), 32'(stk.size()));
        checkVal({tag, ".dout"},  32'(DOUT),  32'(expDout));
        checkVal({tag, ".empty"}, 32'(EMPTY), 32'(stk.size() == 0));
        checkVal({tag, ".full"},  32'(FULL),  32'(stk.size() == DEPTH));
        checkVal({tag, ".ovf"},   32'(OVF),   32'(mOvf & ERR_EN));
        checkVal({tag, ".unf"},   32'(UNF),   32'(mUnf & ERR_EN));
    endtask

    initial begin
        RESET_N = 1'b0;
        PUSH    = 1'b0;
        POP     = 1'b0;
        DIN     = '0;

        // Reset then fill.
        applyStimulus(0, 0, 0, '0);
        applyStimulus(0, 1, 1, 19'h12345);
        checkOutput("reset");
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1, 1, 0, WIDTH'(i));
            checkOutput("fill");
        end
        checkVal("fill.count32", 32'(COUNT), 32'd32);
        checkVal("fill.full",    32'(FULL),  32'd1);
        checkVal("fill.dout",    32'(DOUT),  32'h20);
        checkVal("fill.ovf",     32'(OVF),   32'd0);

        // Overflow from full, flag must stick.
        applyStimulus(1, 1, 0, 19'h7FFFF);
        checkOutput("ovf");
        checkVal("ovf.count", 32'(COUNT), 32'd32);
        checkVal("ovf.dout",  32'(DOUT),  32'h20);
        checkVal("ovf.flag",  32'(OVF),   32'(ERR_EN));
        applyStimulus(1, 0, 0, '0);
        checkVal("ovf.sticky", 32'(OVF), 32'(ERR_EN));

        // Replace-top while full is allowed.
        applyStimulus(1, 1, 1, 19'h00020);
        checkOutput("replFull");

        // Drain, then one extra pop.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 1, '0);
            checkOutput("drain");
            checkVal("drain.step", 32'(DOUT), 32'(DEPTH - 1 - i));
        end
        checkVal("drain.empty", 32'(EMPTY), 32'd1);
        applyStimulus(1, 0, 1, '0);
        checkOutput("unf");
        checkVal("unf.flag",  32'(UNF),   32'(ERR_EN));
        checkVal("unf.count", 32'(COUNT), 32'd0);

        // Replace-top.
        applyStimulus(0, 0, 0, '0);
        applyStimulus(1, 1, 0, 19'h00AAA);
        applyStimulus(1, 1, 1, 19'h00555);
        checkOutput("repl");
        checkVal("repl.count", 32'(COUNT), 32'd1);
        checkVal("repl.dout",  32'(DOUT),  32'h555);

        // Push+pop on empty.
        applyStimulus(0, 0, 0, '0);
        applyStimulus(1, 1, 1, 19'h00123);
        checkOutput("emptyRepl");
        checkVal("emptyRepl.dout", 32'(DOUT), 32'h123);
        checkVal("emptyRepl.unf",  32'(UNF),  32'(ERR_EN));

        // Mid-operation reset with a push pending.
        applyStimulus(0, 0, 0, '0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, WIDTH'(19'h100 + i));
        applyStimulus(1, 0, 1, '0);
        applyStimulus(1, 1, 0, 19'h00777);
        checkVal("mid.count5", 32'(COUNT), 32'd5);
        applyStimulus(0, 1, 0, 19'h55555);
        checkOutput("midReset");
        checkVal("mid.dout", 32'(DOUT), 32'd0);

        // Randomized traffic with push-heavy and pop-heavy phases so both
        // full and empty boundaries are reached repeatedly.
        for (int ph = 0; ph < 16; ph++) begin
            int pushPct;
            pushPct = (ph % 2 == 0) ? 80 : 20;
            for (int c = 0; c < 100; c++) begin
                bit rn;
                bit pu;
                bit po;
                int r;
                rn = ($urandom_range(0, 99) != 0);
                r  = $urandom_range(0, 99);
                pu = (r < pushPct);
                po = ($urandom_range(0, 99) < (100 - pushPct)) || ($urandom_range(0, 9) == 0);
                applyStimulus(rn, pu, po, WIDTH'($urandom));
                checkOutput("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
